// File: rtl/turf_bus_arbiter_if.sv
// rtl/turf_bus_arbiter_if.sv - requester-side register-bus channel for turf_bus_arbiter
// A requester holds req with wr/addr/bank/wdat stable until it sees ack; err qualifies ack.
interface turf_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [5:0]  addr;
  logic [1:0]  bank;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output req, wr, addr, bank, wdat, input rdat, ack, err);
  modport slave  (input req, wr, addr, bank, wdat, output rdat, ack, err);
endinterface

// File: rtl/turf_bus_arbiter.sv
// rtl/turf_bus_arbiter.sv - round-robin arbiter sharing the TURF register bus between two requesters
// One transaction in flight at a time; a missing TURF ack is aborted after TIMEOUT_CYCLES and counted.
module turf_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  turf_bus_arbiter_if.slave       m0,
  turf_bus_arbiter_if.slave       m1,
  output logic                    turf_wr,
  output logic                    turf_rd,
  output logic [5:0]              turf_addr,
  output logic [1:0]              turf_bank,
  output logic [31:0]             turf_wdat,
  input  logic [31:0]             turf_rdat,
  input  logic                    turf_ack,
  input  logic                    to_clr,
  output logic [TO_CNT_WIDTH-1:0] to_count,
  output logic                    busy
);

  // The counter is cleared in ISSUE, so reaching this value in WAIT means the
  // strobe was issued TIMEOUT_CYCLES-1 cycles ago.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        lat_wr;
  logic [15:0] wait_cnt;
  logic        pick;
  logic        done_ok;
  logic        done_to;

  always_comb begin
    pick    = (m0.req && m1.req) ? ~last_grant : m1.req;
    done_ok = ((state == ISSUE) || (state == WAIT)) && turf_ack;
    done_to = (state == WAIT) && !turf_ack && (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_wr     <= 1'b0;
      wait_cnt   <= '0;
      turf_wr    <= 1'b0;
      turf_rd    <= 1'b0;
      turf_addr  <= '0;
      turf_bank  <= '0;
      turf_wdat  <= '0;
      m0.ack     <= 1'b0;
      m0.err     <= 1'b0;
      m0.rdat    <= '0;
      m1.ack     <= 1'b0;
      m1.err     <= 1'b0;
      m1.rdat    <= '0;
      to_count   <= '0;
      busy       <= 1'b0;
    end else begin
      turf_wr <= 1'b0;
      turf_rd <= 1'b0;
      m0.ack  <= 1'b0;
      m1.ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (m0.req || m1.req) begin
            grant     <= pick;
            lat_wr    <= pick ? m1.wr : m0.wr;
            turf_wr   <= pick ? m1.wr : m0.wr;
            turf_rd   <= pick ? !m1.wr : !m0.wr;
            turf_addr <= pick ? m1.addr : m0.addr;
            turf_bank <= pick ? m1.bank : m0.bank;
            turf_wdat <= pick ? m1.wdat : m0.wdat;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (!turf_ack) state <= WAIT;
        end
        WAIT: begin
          if (!done_ok && !done_to) wait_cnt <= wait_cnt + 16'd1;
        end
        DONE: begin
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // An ack on the threshold cycle takes precedence: done_to requires !turf_ack.
      if (done_ok || done_to) begin
        state <= DONE;
        if (grant) begin
          m1.ack <= 1'b1;
          m1.err <= done_to;
          if (done_to)     m1.rdat <= '1;
          else if (!lat_wr) m1.rdat <= turf_rdat;
        end else begin
          m0.ack <= 1'b1;
          m0.err <= done_to;
          if (done_to)     m0.rdat <= '1;
          else if (!lat_wr) m0.rdat <= turf_rdat;
        end
      end

      if (done_to && to_clr)             to_count <= TO_CNT_WIDTH'(1);
      else if (to_clr)                   to_count <= '0;
      else if (done_to && !(&to_count))  to_count <= to_count + 1'b1;
    end
  end

endmodule
